// File: rtl/grey_frame_ctrl.sv
// Raster-order frame sequencer: memory read -> greyscale converter -> grey-buffer write, one pixel at a time.
// 4 cycles/pixel unstalled plus one DONE cycle; stalls in CONV/WRITE hold all pixel outputs until the handshake completes.
module grey_frame_ctrl #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic [11:0]       conv_pixel_in,
    output logic              conv_in_ready,
    input  logic [3:0]        conv_pixel_out,
    input  logic              conv_out_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    input  logic              wr_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPT,
        S_CONV,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int                NPIX     = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pix_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every output below is a pure decode of the state register.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        rd_en         = 1'b0;
        conv_in_ready = 1'b0;
        wr_en         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                busy      = 1'b1;
                rd_en     = 1'b1;
                state_nxt = S_CAPT;
            end
            S_CAPT: begin
                busy      = 1'b1;
                state_nxt = S_CONV;
            end
            S_CONV: begin
                busy          = 1'b1;
                conv_in_ready = 1'b1;
                if (conv_out_ready) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (wr_ready) begin
                    state_nxt = (pix_cnt == LAST_PIX) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt       <= '0;
            conv_pixel_in <= '0;
            wr_addr       <= '0;
            wr_data       <= '0;
        end else begin
            // A beat accepted in the same cycle as abort is deliberately not counted.
            if (abort || state == S_DONE) begin
                pix_cnt <= '0;
            end else if (state == S_WRITE && wr_ready && pix_cnt != LAST_PIX) begin
                pix_cnt <= pix_cnt + ADDR_W'(1);
            end
            if (state == S_CAPT) begin
                conv_pixel_in <= rd_data;
            end
            if (state == S_CONV && conv_out_ready) begin
                wr_data <= conv_pixel_out;
                wr_addr <= pix_cnt;
            end
        end
    end

    assign rd_addr = pix_cnt;

endmodule

// File: tb/tb_grey_frame_ctrl.sv
// Directed bench for grey_frame_ctrl on a 4x2 frame: memory and converter models, write scoreboard.
module tb_grey_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [11:0]   rd_data;
    logic [11:0]   conv_pixel_in;
    logic          conv_in_ready;
    logic [3:0]    conv_pixel_out;
    logic          conv_out_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          wr_ready;
    logic          conv_stall;

    int checks   = 0;
    int failures = 0;

    // Expected writes as {addr, data}.
    logic [7:0] sb_q[$];

    // Per-frame stimulus schedule, in cycles counted from the start edge.
    int start_a, start_b, abort_at, wr_lo, wr_hi, cv_lo, cv_hi, hold_addr;

    grey_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .conv_pixel_in  (conv_pixel_in),
        .conv_in_ready  (conv_in_ready),
        .conv_pixel_out (conv_pixel_out),
        .conv_out_ready (conv_out_ready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray(input logic [11:0] p);
        int s;
        s = 77 * int'(p[11:8]) + 150 * int'(p[7:4]) + 29 * int'(p[3:0]);
        return 4'(s >> 8);
    endfunction

    initial rd_data = '0;
    always @(posedge clk) begin
        if (rd_en) rd_data <= 12'(int'(rd_addr) * 'h111);
    end

    assign conv_pixel_out = gray(conv_pixel_in);
    assign conv_out_ready = conv_in_ready && !conv_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && wr_en && wr_ready) begin
            check("sb_write_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                logic [7:0] e;
                e = sb_q.pop_front();
                check("sb_wr_addr", 32'(wr_addr), 32'(e[7:4]));
                check("sb_wr_data", 32'(wr_data), 32'(e[3:0]));
            end
        end
    end

    // Channels of addr*0x111 are all equal and the weights sum to 256, so grey == addr.
    task automatic push_exp(input int n);
        for (int a = 0; a < n; a++) sb_q.push_back({4'(a), 4'(a)});
    endtask

    task automatic clear_sched();
        start_a = -1; start_b = -1; abort_at = -1;
        wr_lo = -1; wr_hi = -2; cv_lo = -1; cv_hi = -2; hold_addr = 0;
    endtask

    task automatic set_idle();
        start = 1'b0; abort = 1'b0; wr_ready = 1'b1; conv_stall = 1'b0;
    endtask

    task automatic kick();
        set_idle();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drives cycle i of a frame, checks it at the negedge, ends just after the next edge.
    task automatic step(input int i, output bit dn);
        start      = (i == start_a || i == start_b);
        abort      = (i == abort_at);
        wr_ready   = !(i >= wr_lo && i <= wr_hi);
        conv_stall = (i >= cv_lo && i <= cv_hi);
        @(negedge clk);
        if (i == 1) begin
            check("start_busy_rd_en", 32'({busy, rd_en}), 32'b11);
            check("start_rd_addr", 32'(rd_addr), 0);
        end
        if (i >= wr_lo && i <= wr_hi) begin
            check("wr_stall_en", 32'(wr_en), 1);
            check("wr_stall_addr", 32'(wr_addr), 32'(hold_addr));
            check("wr_stall_data", 32'(wr_data), 32'(hold_addr));
        end
        if (i >= cv_lo && i <= cv_hi) begin
            check("conv_stall_pixel", 32'(conv_pixel_in), 32'(hold_addr * 'h111));
            check("conv_stall_no_wr", 32'(wr_en), 0);
        end
        dn = done;
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int exp_n, input string tag);
        bit dn;
        int n;
        n = 0;
        for (int i = 1; i <= 200 && n == 0; i++) begin
            step(i, dn);
            if (dn) n = i;
        end
        set_idle();
        check({tag, "_done_cycle"}, 32'(n), 32'(exp_n));
        @(negedge clk);
        check({tag, "_after_done"}, 32'({busy, done}), 0);
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 0);
    endtask

    initial begin
        bit dn;
        bit dn_any;
        rst = 1'b0;
        set_idle();
        clear_sched();

        @(negedge clk);
        check("reset_outputs", 32'({busy, done, rd_en, rd_addr, conv_pixel_in, conv_in_ready,
                                   wr_en, wr_addr, wr_data}), 0);
        @(negedge clk);
        rst = 1'b1;

        clear_sched(); push_exp(W * H); kick();
        run_frame(33, "plain");

        clear_sched(); wr_lo = 24; wr_hi = 26; hold_addr = 5;
        push_exp(W * H); kick();
        run_frame(36, "wr_stall");

        clear_sched(); cv_lo = 3; cv_hi = 4; hold_addr = 0;
        push_exp(W * H); kick();
        run_frame(35, "conv_stall");

        // Abort in the WRITE of pixel 3 while the sink accepts: that beat reaches the sink.
        clear_sched(); abort_at = 16; push_exp(4); kick();
        dn_any = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step(i, dn);
            dn_any = dn_any | dn;
        end
        set_idle();
        @(negedge clk);
        check("abort_idle", 32'({busy, done, wr_en, rd_en}), 0);
        check("abort_sb_empty", 32'(sb_q.size()), 0);
        repeat (3) begin
            @(negedge clk);
            dn_any = dn_any | done;
        end
        check("abort_no_done", 32'(dn_any), 0);
        @(posedge clk); #1;
        clear_sched(); push_exp(W * H); kick();
        run_frame(33, "restart");

        // Start mid-frame and coincident with done are both dropped.
        clear_sched(); start_a = 10; start_b = 33;
        push_exp(W * H); kick();
        run_frame(33, "start_ignored");
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("no_second_frame", 32'({busy, rd_en}), 0);

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check("start_abort_idle", 32'({busy, rd_en}), 0);

        // Asynchronous reset while in CONV of pixel 1.
        @(posedge clk); #1;
        clear_sched(); push_exp(W * H); kick();
        for (int i = 1; i <= 6; i++) step(i, dn);
        #2;
        check("pre_reset_conv", 32'({conv_in_ready, conv_pixel_in}), 32'({1'b1, 12'h111}));
        rst = 1'b0;
        #1;
        check("async_reset_outputs", 32'({busy, done, rd_en, rd_addr, conv_pixel_in, conv_in_ready,
                                         wr_en, wr_addr, wr_data}), 0);
        sb_q.delete();
        set_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        clear_sched(); push_exp(W * H); kick();
        run_frame(33, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
